// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator state codes, datapath widths and result-stage FSM states
package calc_pkg;
   localparam int CALC_W  = 13;
   localparam int CALC_RW = 2 * CALC_W;
   localparam int CALC_ND = 8;
   localparam logic [5:0] ST_START = 6'd0;
   localparam logic [5:0] ST_ADD   = 6'd9;
   localparam logic [5:0] ST_SUB   = 6'd10;
   localparam logic [5:0] ST_SSUM  = 6'd11;
   localparam logic [5:0] ST_MUL   = 6'd12;
   localparam logic [5:0] ST_ALU   = 6'd13;
   typedef enum logic [1:0] {CTL_IDLE, CTL_MUL, CTL_CONV} ctl_e;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, restartable by start
module bin2bcd_seq #(
   parameter int RW = calc_pkg::CALC_RW,
   parameter int ND = calc_pkg::CALC_ND
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            rst,
   input  logic            start,
   input  logic [RW-1:0]   bin,
   output logic [4*ND-1:0] bcd,
   output logic            done
);
   localparam int SW = 4 * ND + RW;
   localparam int CW = $clog2(RW);
   logic [SW-1:0] sh_q, sh_d, step;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;

   // add 3 to every digit of 5 or more, then shift the whole register left
   function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] s);
      logic [SW-1:0] t;
      t = s;
      for (int i = 0; i < ND; i++)
         if (t[RW+4*i +: 4] >= 4'd5) t[RW+4*i +: 4] = t[RW+4*i +: 4] + 4'd3;
      return {t[SW-2:0], 1'b0};
   endfunction

   // done and bcd reflect the final step so the caller can capture on the same edge
   always_comb begin
      step  = dd_step(sh_q);
      done  = run_q && (cnt_q == CW'(RW - 1));
      bcd   = step[SW-1 -: 4*ND];
      sh_d  = start ? {{(4*ND){1'b0}}, bin} : run_q ? step : sh_q;
      cnt_d = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
      run_d = start || (run_q && !done);
      if (rst) begin
         sh_d  = '0;
         cnt_d = '0;
         run_d = 1'b0;
      end
   end

   // conversion state registers
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         sh_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
endmodule

// File: rtl/calc_result.sv
// calc_result: launches add/sub/mul on state entry, converts to BCD and presents the result
module calc_result #(
   parameter int W  = calc_pkg::CALC_W,
   parameter int RW = calc_pkg::CALC_RW,
   parameter int ND = calc_pkg::CALC_ND
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            rst,
   input  logic [5:0]      state,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   output logic [RW-1:0]   res_mag,
   output logic            neg,
   output logic [4*ND-1:0] bcd,
   output logic            busy,
   output logic            done
);
   import calc_pkg::*;
   localparam int MW = $clog2(W);
   ctl_e            st_q, st_d;
   logic [5:0]      prev_q;
   logic [RW-1:0]   a_q, a_d, mag_q, mag_d, res_q, res_d, mag_step, op_mag, conv_bin;
   logic [W-1:0]    b_q, b_d;
   logic [MW-1:0]   mcnt_q, mcnt_d;
   logic            pneg_q, pneg_d, neg_q, neg_d, done_q, done_d;
   logic [4*ND-1:0] bcd_q, bcd_d, conv_bcd;
   logic            is_op, launch, to_start, mul_last, conv_start, conv_done;

   bin2bcd_seq #(.RW(RW), .ND(ND)) u_conv (
      .clk(clk), .clr(clr), .rst(rst), .start(conv_start), .bin(conv_bin),
      .bcd(conv_bcd), .done(conv_done)
   );

   // launch detection, shift-add multiplier, control FSM and output capture
   always_comb begin
      is_op      = (state == ST_ADD) || (state == ST_SUB) || (state == ST_MUL);
      launch     = is_op && (state != prev_q);
      to_start   = (state == ST_START) && (prev_q != ST_START);
      mag_step   = mag_q + (b_q[0] ? a_q : '0);
      mul_last   = (st_q == CTL_MUL) && (mcnt_q == MW'(W - 1));
      op_mag     = (state == ST_ADD) ? RW'(A) + RW'(B) : (A >= B) ? RW'(A - B) : RW'(B - A);
      conv_start = launch ? (state != ST_MUL) : mul_last;
      conv_bin   = launch ? op_mag : mag_step;
      st_d   = st_q;
      a_d    = a_q;
      b_d    = b_q;
      mag_d  = mag_q;
      mcnt_d = mcnt_q;
      pneg_d = pneg_q;
      res_d  = res_q;
      neg_d  = neg_q;
      bcd_d  = bcd_q;
      done_d = 1'b0;
      if (to_start) begin
         st_d  = CTL_IDLE;
         res_d = '0;
         neg_d = 1'b0;
         bcd_d = '0;
      end else if (launch) begin
         st_d   = (state == ST_MUL) ? CTL_MUL : CTL_CONV;
         a_d    = RW'(A);
         b_d    = B;
         mcnt_d = '0;
         mag_d  = (state == ST_MUL) ? '0 : op_mag;
         pneg_d = (state == ST_SUB) && (A < B);
      end else if (st_q == CTL_MUL) begin
         mag_d  = mag_step;
         a_d    = a_q << 1;
         b_d    = b_q >> 1;
         mcnt_d = mcnt_q + 1'b1;
         st_d   = mul_last ? CTL_CONV : CTL_MUL;
      end else if ((st_q == CTL_CONV) && conv_done) begin
         st_d   = CTL_IDLE;
         res_d  = mag_q;
         neg_d  = pneg_q;
         bcd_d  = conv_bcd;
         done_d = 1'b1;
      end
      if (rst) begin
         st_d   = CTL_IDLE;
         a_d    = '0;
         b_d    = '0;
         mag_d  = '0;
         mcnt_d = '0;
         pneg_d = 1'b0;
         res_d  = '0;
         neg_d  = 1'b0;
         bcd_d  = '0;
         done_d = 1'b0;
      end
   end

   // state, datapath and output registers
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         prev_q <= ST_START;
         st_q   <= CTL_IDLE;
         a_q    <= '0;
         b_q    <= '0;
         mag_q  <= '0;
         mcnt_q <= '0;
         pneg_q <= 1'b0;
         res_q  <= '0;
         neg_q  <= 1'b0;
         bcd_q  <= '0;
         done_q <= 1'b0;
      end else begin
         prev_q <= rst ? ST_START : state;
         st_q   <= st_d;
         a_q    <= a_d;
         b_q    <= b_d;
         mag_q  <= mag_d;
         mcnt_q <= mcnt_d;
         pneg_q <= pneg_d;
         res_q  <= res_d;
         neg_q  <= neg_d;
         bcd_q  <= bcd_d;
         done_q <= done_d;
      end

   assign res_mag = res_q;
   assign neg     = neg_q;
   assign bcd     = bcd_q;
   assign done    = done_q;
   assign busy    = (st_q != CTL_IDLE) || done_q;
endmodule

// File: tb/tb_calc_result.sv
// tb_calc_result: randomized and directed checks of calc_result against an arithmetic model
module tb_calc_result;
   logic        clk, clr, rst, neg, busy, done;
   logic [5:0]  state;
   logic [12:0] A, B;
   logic [25:0] res_mag;
   logic [31:0] bcd;
   int n_cmp = 0, n_bad = 0, done_cnt = 0, dbl = 0, d0;
   logic last_done = 1'b0;

   calc_result dut (
      .clk(clk), .clr(clr), .rst(rst), .state(state), .A(A), .B(B),
      .res_mag(res_mag), .neg(neg), .bcd(bcd), .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // count done pulses and back-to-back pulses
   always @(posedge clk) begin
      #2;
      if (done) begin
         done_cnt++;
         if (last_done) dbl++;
      end
      last_done = done;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic longint m_mag(input int op, input int a, input int b);
      return (op == 9) ? longint'(a + b) : (op == 10) ? longint'((a > b) ? a - b : b - a) : longint'(a) * longint'(b);
   endfunction

   function automatic logic [31:0] m_bcd(input longint v);
      logic [31:0] r;
      longint x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic park();
      @(negedge clk);
      state = 6'd13;
   endtask

   task automatic launch(input int op, input int a, input int b);
      @(negedge clk);
      A = 13'(a);
      B = 13'(b);
      state = 6'(op);
   endtask

   // called right after launch; the next rising edge is the launch edge
   task automatic expect_result(input string tag, input int lat, input longint mag, input bit ng);
      int n;
      bit got;
      n = -1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 0) check({tag, "_busy0"}, busy, 1);
         if (done) got = 1'b1;
      end
      check({tag, "_lat"}, got ? n : -1, lat);
      check({tag, "_mag"}, res_mag, mag);
      check({tag, "_neg"}, neg, ng);
      check({tag, "_bcd"}, bcd, m_bcd(mag));
      check({tag, "_busy"}, busy, 1);
      @(negedge clk);
      check({tag, "_done1"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic run_op(input string tag, input int op, input int a, input int b);
      park();
      launch(op, a, b);
      expect_result(tag, (op == 12) ? 39 : 26, m_mag(op, a, b), (op == 10) && (a < b));
   endtask

   task automatic zero_outs(input string tag);
      check({tag, "_mag"}, res_mag, 0);
      check({tag, "_neg"}, neg, 0);
      check({tag, "_bcd"}, bcd, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      int op, a, b;
      clr = 1'b1;
      rst = 1'b0;
      state = 6'd0;
      A = '0;
      B = '0;
      #12;
      zero_outs("reset");
      check("reset_busy", busy, 0);
      @(negedge clk);
      clr = 1'b0;
      run_op("add", 9, 1234, 567);
      check("add_bcd_lit", bcd, 32'h00001801);
      @(negedge clk);
      state = 6'd0;
      d0 = done_cnt;
      @(negedge clk);
      zero_outs("start_clr");
      repeat (5) @(negedge clk);
      check("start_nodone", done_cnt - d0, 0);
      run_op("sub_neg", 10, 25, 100);
      check("sub_bcd_lit", bcd, 32'h00000075);
      run_op("sub_eq", 10, 500, 500);
      run_op("mul_max", 12, 8191, 8191);
      check("mul_bcd_lit", bcd, 32'h67092481);
      park();
      launch(12, 12, 12);
      d0 = done_cnt;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 5) A = 13'd99;
      end
      check("hold_dones", done_cnt - d0, 1);
      check("hold_mag", res_mag, 144);
      park();
      launch(12, 100, 100);
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      launch(9, 3, 4);
      expect_result("abort", 26, 7, 0);
      repeat (30) @(negedge clk);
      check("abort_dones", done_cnt - d0, 1);
      park();
      launch(9, 20, 30);
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      state = 6'd0;
      repeat (40) @(negedge clk);
      check("start_abort_dones", done_cnt - d0, 0);
      check("start_abort_busy", busy, 0);
      run_op("pre_clr", 9, 1, 2);
      park();
      launch(12, 50, 60);
      d0 = done_cnt;
      repeat (10) @(negedge clk);
      clr = 1'b1;
      state = 6'd11;
      #1;
      zero_outs("clr");
      check("clr_busy", busy, 0);
      @(negedge clk);
      clr = 1'b0;
      repeat (60) @(negedge clk);
      check("clr_dones", done_cnt - d0, 0);
      zero_outs("clr_after");
      run_op("pre_rst", 9, 4, 5);
      park();
      launch(12, 70, 80);
      d0 = done_cnt;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      state = 6'd11;
      @(negedge clk);
      rst = 1'b0;
      zero_outs("rst");
      check("rst_busy", busy, 0);
      repeat (60) @(negedge clk);
      check("rst_dones", done_cnt - d0, 0);
      for (int i = 0; i < 24; i++) begin
         op = 9 + int'($urandom_range(0, 2));
         if (op == 11) op = 12;
         a = (i % 8 == 0) ? 8191 : int'($urandom_range(0, 8191));
         b = (i % 8 == 1) ? 0 : int'($urandom_range(0, 8191));
         run_op("rnd", op, a, b);
      end
      check("no_double_done", dbl, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
